// File: rtl/dec_pkg.sv
// Shared types and helpers for the dec_scan_n decoder slice.
package dec_pkg;

  // Controller states: IDLE serves direct decodes, SCAN sweeps the counter,
  // DONE drains the final beat before pulsing scan_done.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of one-hot lines produced by a w-bit binary field.
  function automatic int onehot_w(input int w);
    return 1 << w;
  endfunction

endpackage

// File: rtl/dec_pre_n.sv
// Combinational two-level predecoded N-to-2^N one-hot decoder.
// The address splits into an upper field (HI_W bits) and a lower field
// (IN_W-HI_W bits); each is decoded separately and the final lines are the
// AND of one upper line with the whole lower one-hot vector.
module dec_pre_n
  import dec_pkg::*;
#(
  parameter int IN_W = 5,
  parameter int HI_W = 3,
  localparam int OUT_W = onehot_w(IN_W)
) (
  input  logic [IN_W-1:0]  addr,
  output logic [OUT_W-1:0] out
);

  localparam int LO_W = IN_W - HI_W;
  localparam int HI_N = onehot_w(HI_W);
  localparam int LO_N = onehot_w(LO_W);

  logic [HI_N-1:0] hi_oh;
  logic [LO_N-1:0] lo_oh;

  // Upper-field predecode: exactly one of HI_N lines active.
  always_comb begin
    hi_oh = '0;
    hi_oh[addr[IN_W-1:LO_W]] = 1'b1;
  end

  // Lower-field predecode: exactly one of LO_N lines active.
  always_comb begin
    lo_oh = '0;
    lo_oh[addr[LO_W-1:0]] = 1'b1;
  end

  // Each upper line gates a copy of the lower one-hot into its output group.
  for (genvar k = 0; k < HI_N; k++) begin : g_group
    assign out[k*LO_N +: LO_N] = {LO_N{hi_oh[k]}} & lo_oh;
  end

endmodule

// File: rtl/dec_scan_n.sv
// Registered one-hot decoder with direct and scan modes, valid/ready on
// both sides. Optional feature macro: DEC_SCAN_IDX_EN adds out_idx, the
// binary index of the asserted out bit, registered alongside out.
module dec_scan_n
  import dec_pkg::*;
#(
  parameter int IN_W = 5,
  parameter int HI_W = 3,
  localparam int OUT_W = onehot_w(IN_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_addr,
  input  logic             scan_start,
  input  logic             scan_stop,
  input  logic [IN_W-1:0]  scan_first,
  input  logic [IN_W-1:0]  scan_last,
  output logic [OUT_W-1:0] out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             scan_busy,
  output logic             scan_done
`ifdef DEC_SCAN_IDX_EN
  ,
  output logic [IN_W-1:0]  out_idx
`endif
);

  state_t            state;
  state_t            state_nxt;
  logic [IN_W-1:0]   cnt;
  logic [IN_W-1:0]   cnt_nxt;
  logic [IN_W-1:0]   last;
  logic [IN_W-1:0]   last_nxt;
  logic              load_ok;
  logic              load;
  logic              sel_scan;
  logic              done_nxt;
  logic [IN_W-1:0]   dec_addr;
  logic [OUT_W-1:0]  dec_out;

  // The output slot can take a new beat when empty or being drained now.
  assign load_ok   = !out_valid || out_ready;
  assign scan_busy = (state == SCAN);
  assign dec_addr  = sel_scan ? cnt : in_addr;

  dec_pre_n #(
    .IN_W(IN_W),
    .HI_W(HI_W)
  ) u_pre (
    .addr(dec_addr),
    .out (dec_out)
  );

  // Next-state, handshake and load decisions for the three-state controller.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    last_nxt  = last;
    load      = 1'b0;
    sel_scan  = 1'b0;
    done_nxt  = 1'b0;
    in_ready  = 1'b0;
    case (state)
      IDLE: begin
        if (scan_start) begin
          cnt_nxt   = scan_first;
          last_nxt  = scan_last;
          state_nxt = SCAN;
        end else begin
          in_ready = load_ok;
          load     = in_valid && load_ok;
        end
      end
      SCAN: begin
        sel_scan = 1'b1;
        if (scan_stop) begin
          state_nxt = DONE;
        end else if (load_ok) begin
          load = 1'b1;
          if (cnt == last) begin
            state_nxt = DONE;
          end else begin
            cnt_nxt = cnt + IN_W'(1);
          end
        end
      end
      DONE: begin
        if (load_ok) begin
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    if (rst) begin
      in_ready = 1'b0;
    end
  end

  // Controller state, scan counter, latched end address and done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      last      <= '0;
      scan_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      last      <= last_nxt;
      scan_done <= done_nxt;
    end
  end

  // Output register slot: load a decoded beat, or clear once consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      out       <= '0;
      out_valid <= 1'b0;
    end else if (load) begin
      out       <= dec_out;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out       <= '0;
      out_valid <= 1'b0;
    end
  end

`ifdef DEC_SCAN_IDX_EN
  // Binary index shadow of the one-hot output, cleared with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_idx <= '0;
    end else if (load) begin
      out_idx <= dec_addr;
    end else if (out_ready) begin
      out_idx <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_dec_scan_n.sv
// Self-checking bench for dec_scan_n (IN_W=5, HI_W=3): table-driven direct
// mode vectors plus hand-written scan, stall, abort and reset sequences.
module tb_dec_scan_n;

  localparam int IN_W  = 5;
  localparam int OUT_W = 32;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_addr;
  logic             scan_start;
  logic             scan_stop;
  logic [IN_W-1:0]  scan_first;
  logic [IN_W-1:0]  scan_last;
  logic [OUT_W-1:0] out;
  logic             out_valid;
  logic             out_ready;
  logic             scan_busy;
  logic             scan_done;
`ifdef DEC_SCAN_IDX_EN
  logic [IN_W-1:0]  out_idx;
`endif

  int n_tests;
  int n_fail;

  typedef struct {
    logic            in_valid;
    logic [IN_W-1:0] in_addr;
    logic            out_ready;
    logic            exp_in_ready;
    logic [31:0]     exp_out;
    logic            exp_valid;
  } vec_t;

  vec_t vecs[$];

  dec_scan_n #(
    .IN_W(5),
    .HI_W(3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_addr   (in_addr),
    .scan_start(scan_start),
    .scan_stop (scan_stop),
    .scan_first(scan_first),
    .scan_last (scan_last),
    .out       (out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .scan_busy (scan_busy),
    .scan_done (scan_done)
`ifdef DEC_SCAN_IDX_EN
    ,
    .out_idx   (out_idx)
`endif
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop if the sequence ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_output(input string name, input logic [31:0] e_out, input logic e_valid,
                              input logic e_busy, input logic e_done);
    check_val({name, ".out"}, out, e_out);
    check_val({name, ".out_valid"}, {31'd0, out_valid}, {31'd0, e_valid});
    check_val({name, ".scan_busy"}, {31'd0, scan_busy}, {31'd0, e_busy});
    check_val({name, ".scan_done"}, {31'd0, scan_done}, {31'd0, e_done});
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input vec_t v, input int idx);
    in_valid  = v.in_valid;
    in_addr   = v.in_addr;
    out_ready = v.out_ready;
    #1;
    check_val($sformatf("vec%0d.in_ready", idx), {31'd0, in_ready}, {31'd0, v.exp_in_ready});
    cycle();
    check_output($sformatf("vec%0d", idx), v.exp_out, v.exp_valid, 1'b0, 1'b0);
  endtask

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_addr    = '0;
    scan_start = 1'b0;
    scan_stop  = 1'b0;
    scan_first = '0;
    scan_last  = '0;
    out_ready  = 1'b1;

    // Direct sweep 0..31 back-to-back, then the 7/9 backpressure case.
    for (int i = 0; i < 32; i++) begin
      vecs.push_back('{1'b1, IN_W'(i), 1'b1, 1'b1, 32'h1 << i, 1'b1});
    end
    vecs.push_back('{1'b1, 5'd7, 1'b1, 1'b1, 32'h0000_0080, 1'b1});
    for (int i = 0; i < 3; i++) begin
      vecs.push_back('{1'b1, 5'd9, 1'b0, 1'b0, 32'h0000_0080, 1'b1});
    end
    vecs.push_back('{1'b1, 5'd9, 1'b1, 1'b1, 32'h0000_0200, 1'b1});
    vecs.push_back('{1'b0, 5'd0, 1'b1, 1'b1, 32'h0000_0000, 1'b0});

    // Reset state.
    #1;
    check_val("reset.in_ready", {31'd0, in_ready}, 32'd0);
    cycle();
    check_output("reset", 32'h0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      apply_stimulus(vecs[i], i);
    end
    in_valid = 1'b0;

    // Wrapping scan 30 -> 1.
    out_ready  = 1'b1;
    scan_first = 5'd30;
    scan_last  = 5'd1;
    scan_start = 1'b1;
    #1;
    check_val("wrap.in_ready", {31'd0, in_ready}, 32'd0);
    cycle();
    scan_start = 1'b0;
    check_output("wrap.enter", 32'h0, 1'b0, 1'b1, 1'b0);
    cycle(); check_output("wrap.b30", 32'h4000_0000, 1'b1, 1'b1, 1'b0);
    cycle(); check_output("wrap.b31", 32'h8000_0000, 1'b1, 1'b1, 1'b0);
    cycle(); check_output("wrap.b0",  32'h0000_0001, 1'b1, 1'b1, 1'b0);
    cycle(); check_output("wrap.b1",  32'h0000_0002, 1'b1, 1'b0, 1'b0);
    cycle(); check_output("wrap.done", 32'h0, 1'b0, 1'b0, 1'b1);
    cycle(); check_output("wrap.idle", 32'h0, 1'b0, 1'b0, 1'b0);

    // Single-beat scan at 5 with a two-cycle stall.
    out_ready  = 1'b0;
    scan_first = 5'd5;
    scan_last  = 5'd5;
    scan_start = 1'b1;
    cycle();
    scan_start = 1'b0;
    check_output("single.enter", 32'h0, 1'b0, 1'b1, 1'b0);
    cycle(); check_output("single.beat", 32'h20, 1'b1, 1'b0, 1'b0);
    cycle(); check_output("single.stall1", 32'h20, 1'b1, 1'b0, 1'b0);
    cycle(); check_output("single.stall2", 32'h20, 1'b1, 1'b0, 1'b0);
    out_ready = 1'b1;
    cycle(); check_output("single.done", 32'h0, 1'b0, 1'b0, 1'b1);
    cycle(); check_output("single.idle", 32'h0, 1'b0, 1'b0, 1'b0);

    // Abort a full sweep at the fourth beat.
    scan_first = 5'd0;
    scan_last  = 5'd31;
    scan_start = 1'b1;
    cycle();
    scan_start = 1'b0;
    check_output("abort.enter", 32'h0, 1'b0, 1'b1, 1'b0);
    cycle(); check_output("abort.b0", 32'h1, 1'b1, 1'b1, 1'b0);
    cycle(); check_output("abort.b1", 32'h2, 1'b1, 1'b1, 1'b0);
    cycle(); check_output("abort.b2", 32'h4, 1'b1, 1'b1, 1'b0);
    cycle(); check_output("abort.b3", 32'h8, 1'b1, 1'b1, 1'b0);
    scan_stop = 1'b1;
    cycle(); check_output("abort.drain", 32'h0, 1'b0, 1'b0, 1'b0);
    cycle(); check_output("abort.done", 32'h0, 1'b0, 1'b0, 1'b1);
    scan_stop = 1'b0;
    #1;
    check_val("abort.in_ready", {31'd0, in_ready}, 32'd1);
    cycle(); check_output("abort.idle", 32'h0, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of a scan: no done pulse afterwards.
    scan_start = 1'b1;
    cycle();
    scan_start = 1'b0;
    cycle(); check_output("rstmid.b0", 32'h1, 1'b1, 1'b1, 1'b0);
    cycle(); check_output("rstmid.b1", 32'h2, 1'b1, 1'b1, 1'b0);
    rst = 1'b1;
    #1;
    check_val("rstmid.in_ready", {31'd0, in_ready}, 32'd0);
    cycle(); check_output("rstmid.reset", 32'h0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    cycle(); check_output("rstmid.quiet1", 32'h0, 1'b0, 1'b0, 1'b0);
    cycle(); check_output("rstmid.quiet2", 32'h0, 1'b0, 1'b0, 1'b0);

    // scan_start beats in_valid in IDLE.
    in_valid   = 1'b1;
    in_addr    = 5'd3;
    scan_first = 5'd10;
    scan_last  = 5'd11;
    scan_start = 1'b1;
    #1;
    check_val("prio.in_ready", {31'd0, in_ready}, 32'd0);
    cycle();
    scan_start = 1'b0;
    in_valid   = 1'b0;
    check_output("prio.enter", 32'h0, 1'b0, 1'b1, 1'b0);
    cycle(); check_output("prio.b10", 32'h400, 1'b1, 1'b1, 1'b0);
    cycle(); check_output("prio.b11", 32'h800, 1'b1, 1'b0, 1'b0);
    cycle(); check_output("prio.done", 32'h0, 1'b0, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dec_scan_n.md
Name: dec_scan_n

Overview:
- Parametrised, registered N-to-2^N one-hot decoder with valid/ready handshakes on input and output.
- Two modes:
  - Direct: decodes one address per accepted input beat.
  - Scan: an internal counter sweeps an address range, emitting one one-hot beat per accepted output.
- Drives row/bank selects and strobe sequencing from control logic.

Parameters:
- IN_W, 5, address width; output width OUT_W = 2**IN_W (localparam, not overridable).
- HI_W, 3, upper-field width for the two-level predecode split; LO_W = IN_W - HI_W. Legal range: 1 <= HI_W < IN_W.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  direct-mode address valid.
- in_ready  out  1  direct-mode address accepted when in_valid && in_ready.
- in_addr  in  IN_W  direct-mode address.
- scan_start  in  1  one-cycle request to begin a scan; sampled only in IDLE.
- scan_stop  in  1  abort active scan.
- scan_first  in  IN_W  first scan address, sampled with scan_start.
- scan_last  in  IN_W  last scan address (inclusive), sampled with scan_start.
- out  out  OUT_W  registered one-hot select.
- out_valid  out  1  out holds a beat.
- out_ready  in  1  downstream consumes beat when out_valid && out_ready.
- scan_busy  out  1  high while in SCAN state.
- scan_done  out  1  one-cycle pulse after last scan beat is consumed or on stop.

Behaviour:
- Reset: state=IDLE; out=0; out_valid=0; scan_busy=0; scan_done=0; scan counter=0; in_ready=0 during the reset cycle.
- Output register slot:
  - Loads when empty or being consumed (load_ok = !out_valid || out_ready).
  - When out_valid=0, out is driven to 0. out is one-hot iff out_valid=1.
- States: IDLE (direct mode), SCAN, DONE.
- IDLE:
  - in_ready = load_ok.
  - An accepted in_addr produces out = 1 << in_addr with out_valid=1 on the next edge (latency 1).
  - Back-to-back beats give full throughput.
  - scan_start=1 in IDLE has priority over in_valid: the address is not accepted, in_ready=0 that cycle.
  - Latch first/last, cnt = scan_first, then go to SCAN.
- SCAN:
  - in_ready=0; scan_busy=1.
  - Each cycle load_ok=1: out = 1 << cnt, out_valid=1.
  - If cnt == last, go to DONE; otherwise cnt = cnt + 1 modulo 2**IN_W (wrap-around, so last < first is legal).
  - first == last produces exactly one beat. A full sweep needs last = first - 1 mod 2**IN_W; beat count = ((last - first) mod 2**IN_W) + 1.
  - Backpressure (out_valid && !out_ready) holds out and cnt unchanged.
- DONE:
  - Waits until the final beat is consumed (out_valid=0, or out_ready=1 that cycle).
  - Then scan_done=1 for one cycle and return to IDLE; in_ready is 0 in DONE.
- scan_stop in SCAN or DONE:
  - The beat already in the output register is retained until consumed; no new beats are loaded.
  - Then pulse scan_done and return to IDLE.
  - scan_stop in IDLE is ignored.
- scan_start outside IDLE is ignored.
- rst mid-scan: everything returns to reset values next edge; no scan_done pulse.
- Decode datapath: two-level predecode.
  - hi = addr[IN_W-1:LO_W] -> 2**HI_W one-hot; lo = addr[LO_W-1:0] -> 2**LO_W one-hot.
  - out[k*2**LO_W +: 2**LO_W] = {2**LO_W{hi_oh[k]}} & lo_oh.

Optional Feature:
- Macro DEC_SCAN_IDX_EN.
- Defined:
  - Adds output port out_idx [IN_W-1:0], the binary index of the asserted out bit, registered alongside out.
  - Reset 0; 0 when out_valid=0.
- Undefined: port absent, no extra registers; all other behaviour identical.

Decomposition:
- Package dec_pkg:
  - state enum (IDLE, SCAN, DONE).
  - Function onehot_w(w) = 2**w.
- Sub-module dec_pre_n: combinational predecoded decoder, parameters IN_W and HI_W, address in and OUT_W one-hot out. The datapath instantiates it once on the mux of in_addr/cnt.

Test Plan:
- Direct sweep: IN_W=5, out_ready=1, in_addr 0..31 back-to-back -> out = 1<<addr one cycle after each accept, 32 consecutive valid beats, never two bits set.
- Backpressure: in_addr=7 then 9, out_ready=0 for 3 cycles -> out holds 0x80, in_ready=0 while full; after out_ready=1, 0x200 follows next cycle.
- Wrapping scan: first=30, last=1 -> beats 1<<30, 1<<31, 1<<0, 1<<1, then scan_done one cycle after last consumed; scan_busy high throughout SCAN.
- Single-beat scan with stall: first=last=5, out_ready low 2 cycles -> exactly one beat 0x20, scan_done only after consumption.
- Abort: scan first=0, last=31, scan_stop at 4th beat -> at most the pending beat delivered, then scan_done, IDLE, in_ready returns.
- Reset mid-scan plus priority: rst asserted during SCAN -> out=0, out_valid=0, no scan_done. Then scan_start and in_valid both high in IDLE -> scan begins, address not accepted.
